// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial subtractor. Computes a - b - bin (modulo 2^WIDTH)
//            one bit per clock, LSB first, through a single full-subtractor
//            cell. The result and final borrow are published together when
//            the operation completes and are held until the next completion.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous active-high reset
//            start      - begin a subtraction (accepted in IDLE only)
//            a, b       - minuend / subtrahend, captured on accepted start
//            bin        - borrow-in, captured on accepted start
//            difference - last completed result
//            borrow     - last completed borrow-out of the MSB stage
//            busy       - high while bits are being processed
//            done       - one-cycle pulse when a new result is valid
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] difference,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    // Counter must reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, z_d;
    logic             borrow_q, borrow_d;

    logic [WIDTH-1:0] w_bit_mask;
    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_shifted;

    // Operands stay untouched after capture; the current bit is selected
    // by the counter instead of shifting the operand registers.
    assign w_bit_mask = WIDTH'(1) << cnt_q;
    assign w_x        = |(a_q & w_bit_mask);
    assign w_y        = |(b_q & w_bit_mask);

    // Full-subtractor cell.
    assign w_d    = w_x ^ w_y ^ z_q;
    assign w_bout = (~w_x & w_y) | (~(w_x ^ w_y) & z_q);

    // New bit enters at the MSB so that after WIDTH shifts the LSB-first
    // stream sits in natural bit order. Written as a full-width shift plus
    // MSB overwrite so it is also valid for WIDTH=1.
    always_comb begin
        w_res_shifted            = res_q >> 1;
        w_res_shifted[WIDTH-1]   = w_d;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        z_d      = z_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    z_d     = bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                res_d = w_res_shifted;
                z_d   = w_bout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == c_last_bit) begin
                    // Publish the complete result on the same edge as DONE.
                    diff_d   = w_res_shifted;
                    borrow_d = w_bout;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            z_q      <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            borrow_q <= borrow_d;
        end
    end

    assign difference = diff_q;
    assign borrow     = borrow_q;
    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor. Two instances
//            (WIDTH=8 and WIDTH=1) are driven from shared operand buses with
//            separate start strobes; results are compared against a plain
//            arithmetic reference of a - b - bin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start8;
    logic       start1;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_bin;

    logic [7:0] diff8;
    logic       borrow8;
    logic       busy8;
    logic       done8;
    logic [0:0] diff1;
    logic       borrow1;
    logic       busy1;
    logic       done1;

    int n_checks;
    int n_fail;

    // Last published result per instance (index 0: WIDTH=8, 1: WIDTH=1).
    logic [7:0] prev_diff   [2];
    logic       prev_borrow [2];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a          (op_a),
        .b          (op_b),
        .bin        (op_bin),
        .difference (diff8),
        .borrow     (borrow8),
        .busy       (busy8),
        .done       (done8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .a          (op_a[0:0]),
        .b          (op_b[0:0]),
        .bin        (op_bin),
        .difference (diff1),
        .borrow     (borrow1),
        .busy       (busy1),
        .done       (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] obs_diff(input bit sel);
        return sel ? {7'b0, diff1} : diff8;
    endfunction
    function automatic logic obs_borrow(input bit sel);
        return sel ? borrow1 : borrow8;
    endfunction
    function automatic logic obs_busy(input bit sel);
        return sel ? busy1 : busy8;
    endfunction
    function automatic logic obs_done(input bit sel);
        return sel ? done1 : done8;
    endfunction

    // One complete operation on the selected instance. Inputs are driven on
    // the falling edge; outputs are sampled on falling edges. When perturb
    // is set, operands are scrambled and start is pulsed mid-operation.
    task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic bi, input bit perturb);
        int         w;
        int         ia;
        int         ib;
        int         full;
        logic [7:0] mask;
        logic [7:0] exp_d;
        logic       exp_b;
        w    = sel ? 1 : 8;
        mask = sel ? 8'h01 : 8'hFF;
        ia   = int'(av & mask);
        ib   = int'(bv & mask);
        full = ia - ib - int'(bi);
        exp_b = (full < 0);
        exp_d = 8'((full + 256) % 256) & mask;

        @(negedge clk);
        op_a   = av;
        op_b   = bv;
        op_bin = bi;
        if (sel) start1 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start8 = 1'b0;
        for (int i = 0; i < w; i++) begin
            check("busy_in_shift", 32'(obs_busy(sel)), 32'd1);
            check("no_done_in_shift", 32'(obs_done(sel)), 32'd0);
            check("diff_hold", 32'(obs_diff(sel)), 32'(prev_diff[sel]));
            check("borrow_hold", 32'(obs_borrow(sel)), 32'(prev_borrow[sel]));
            if (perturb) begin
                op_a   = 8'($urandom);
                op_b   = 8'($urandom);
                op_bin = 1'($urandom);
                if (sel) start1 = 1'b1; else start8 = 1'b1;
            end
            @(negedge clk);
        end
        check("done_pulse", 32'(obs_done(sel)), 32'd1);
        check("busy_low_in_done", 32'(obs_busy(sel)), 32'd0);
        check("difference", 32'(obs_diff(sel)), 32'(exp_d));
        check("borrow", 32'(obs_borrow(sel)), 32'(exp_b));
        start1 = 1'b0;
        start8 = 1'b0;
        prev_diff[sel]   = exp_d;
        prev_borrow[sel] = exp_b;
        @(negedge clk);
        check("done_one_cycle", 32'(obs_done(sel)), 32'd0);
        check("idle_not_busy", 32'(obs_busy(sel)), 32'd0);
        check("diff_after_done", 32'(obs_diff(sel)), 32'(exp_d));
        check("borrow_after_done", 32'(obs_borrow(sel)), 32'(exp_b));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_diff8"}, 32'(diff8), 32'd0);
        check({tag, "_borrow8"}, 32'(borrow8), 32'd0);
        check({tag, "_busy8"}, 32'(busy8), 32'd0);
        check({tag, "_done8"}, 32'(done8), 32'd0);
        check({tag, "_diff1"}, 32'(diff1), 32'd0);
        check({tag, "_done1"}, 32'(done1), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        start8   = 1'b0;
        start1   = 1'b0;
        op_a     = '0;
        op_b     = '0;
        op_bin   = 1'b0;
        prev_diff[0] = '0;
        prev_diff[1] = '0;
        prev_borrow[0] = 1'b0;
        prev_borrow[1] = 1'b0;

        // Reset is asserted before any clock edge, so outputs must clear
        // asynchronously.
        rst = 1'b1;
        #2;
        check_all_zero("reset_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset_state");

        // Directed WIDTH=8 cases.
        run_op(1'b0, 8'h05, 8'h03, 1'b0, 1'b0);
        run_op(1'b0, 8'h03, 8'h05, 1'b0, 1'b0);
        run_op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        run_op(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);

        // WIDTH=1 full truth table, index bits = {a, b, bin}.
        for (int k = 0; k < 8; k++) begin
            run_op(1'b1, {7'b0, k[2]}, {7'b0, k[1]}, k[0], 1'b0);
        end

        // Reset in the middle of an operation.
        @(negedge clk);
        op_a   = 8'h80;
        op_b   = 8'h01;
        op_bin = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        prev_diff[0] = '0;
        prev_diff[1] = '0;
        prev_borrow[0] = 1'b0;
        prev_borrow[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("no_done_after_abort", 32'(done8), 32'd0);
            check("idle_after_abort", 32'(busy8), 32'd0);
            @(negedge clk);
        end
        run_op(1'b0, 8'h80, 8'h01, 1'b0, 1'b0);

        // Randomized operations on both widths.
        for (int i = 0; i < 25; i++) begin
            run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) begin
            run_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
